mcu_bus_bridge: RTL and testbench

//  Parametrised MCU parallel-bus slave bridge. It synchronises an asynchronous ADDR/RD/WR/DATA bus into the clk domain.
//  It decodes NCH consecutive word addresses from BASE into one-hot read and write strobes.
//  It multiplexes NCH read words onto a tri-state DATA bus.
//  It sits between the MCU pins and the peripheral blocks: key scanner, SPI ADC reader, SPWM and similar.

---
 rtl/mcu_bus_bridge.sv | 143 ++++++++++++++
 tb/tb_mcu_bus_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_bus_bridge.sv
// mcu_bus_bridge: synchronised MCU parallel-bus slave decoding NCH word channels from BASE.
// Define BUS_SNAPSHOT_EN to make a channel-0 read freeze all channels into a coherent shadow bank.
module mcu_bus_bridge #(
    parameter int            AW          = 12,
    parameter int            DW          = 16,
    parameter int            NCH         = 8,
    parameter logic [AW-1:0] BASE        = '0,
    parameter int            SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ADDR,
    input  logic              RD,
    input  logic              WR,
    inout  wire  [DW-1:0]     DATA,
    input  logic [NCH*DW-1:0] rd_data,
    output logic [NCH-1:0]    rd_cs,
    output logic [NCH-1:0]    wr_cs,
    output logic [DW-1:0]     wr_data,
    output logic              bus_err
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0][AW-1:0] addr_q;
    logic [SYNC_STAGES-1:0][DW-1:0] data_q;
    logic [SYNC_STAGES-1:0]         rd_q, wr_q;
    // Edge detection stays blind until the chains hold only post-reset samples.
    logic [SYNC_STAGES:0]           warm;
    logic                           rd_prev, wr_prev;
    logic                           rd_s, wr_s, rd_fall, rd_rise, wr_fall, wr_rise;
    logic [AW:0]                    diff;
    logic                           valid, ch_ok;
    logic [CW-1:0]                  ch, ch_q;
    logic [DW-1:0]                  rd_word, rd_reg;
    logic                           drive_en, start_rd, start_wr, end_wr, err;

    assign rd_s    = rd_q[SYNC_STAGES-1];
    assign wr_s    = wr_q[SYNC_STAGES-1];
    assign rd_fall = warm[SYNC_STAGES] & rd_prev & ~rd_s;
    assign rd_rise = warm[SYNC_STAGES] & ~rd_prev & rd_s;
    assign wr_fall = warm[SYNC_STAGES] & wr_prev & ~wr_s;
    assign wr_rise = warm[SYNC_STAGES] & ~wr_prev & wr_s;
    // A borrow into bit AW pushes addresses below BASE out of range.
    assign diff    = {1'b0, addr_q[SYNC_STAGES-1]} - {1'b0, BASE};
    assign valid   = diff < (AW+1)'(NCH);
    assign ch      = diff[CW-1:0];
    assign DATA    = drive_en ? rd_reg : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '1;
            wr_q    <= '1;
            warm    <= '0;
            rd_prev <= 1'b1;
            wr_prev <= 1'b1;
        end else begin
            addr_q  <= {addr_q[SYNC_STAGES-2:0], ADDR};
            data_q  <= {data_q[SYNC_STAGES-2:0], DATA};
            rd_q    <= {rd_q[SYNC_STAGES-2:0], RD};
            wr_q    <= {wr_q[SYNC_STAGES-2:0], WR};
            warm    <= {warm[SYNC_STAGES-1:0], 1'b1};
            rd_prev <= rd_s;
            wr_prev <= wr_s;
        end
    end

`ifdef BUS_SNAPSHOT_EN
    logic [NCH*DW-1:0] shadow;
    always_ff @(posedge clk) begin
        if (rst)
            shadow <= '0;
        else if (start_rd && valid && ch == '0)
            shadow <= rd_data;
    end
    assign rd_word = ch == '0 ? rd_data[DW-1:0] : shadow[ch*DW +: DW];
`else
    assign rd_word = rd_data[ch*DW +: DW];
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_rd = 1'b0;
        start_wr = 1'b0;
        end_wr   = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                start_rd = rd_fall & wr_s;
                start_wr = wr_fall & rd_s;
                err      = (~rd_s & ~wr_s) | (start_rd & ~valid);
                state_nx = start_rd ? READ : start_wr ? WRITE : IDLE;
            end
            READ: begin
                err      = wr_fall;
                state_nx = rd_rise ? IDLE : READ;
            end
            WRITE: begin
                end_wr   = wr_rise;
                err      = rd_fall | (wr_rise & ~ch_ok);
                state_nx = wr_rise ? IDLE : WRITE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cs    <= '0;
            wr_cs    <= '0;
            wr_data  <= '0;
            bus_err  <= 1'b0;
            drive_en <= 1'b0;
            rd_reg   <= '0;
            ch_q     <= '0;
            ch_ok    <= 1'b0;
        end else begin
            rd_cs    <= start_rd && valid ? NCH'(1) << ch : '0;
            wr_cs    <= end_wr && ch_ok ? NCH'(1) << ch_q : '0;
            bus_err  <= bus_err | err;
            drive_en <= state == READ && !rd_rise;
            if (start_rd || start_wr) begin
                ch_q  <= ch;
                ch_ok <= valid;
            end
            if (start_rd)
                rd_reg <= valid ? rd_word : '0;
            if (end_wr && ch_ok)
                wr_data <= data_q[SYNC_STAGES-1];
        end
    end
endmodule

// File: tb/tb_mcu_bus_bridge.sv
// tb_mcu_bus_bridge: directed and randomised transaction checks for mcu_bus_bridge.
// Expected values come from a transaction-level model of the channel map.
module tb_mcu_bus_bridge;
    localparam int AW = 12, DW = 16, NCH = 8, S = 2;
`ifdef BUS_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic              clk = 1'b0, rst = 1'b1;
    logic [AW-1:0]     addr = '0;
    logic              rd = 1'b1, wr = 1'b1, tb_oe = 1'b0;
    logic [DW-1:0]     tb_dq = '0;
    wire  [DW-1:0]     data;
    logic [NCH*DW-1:0] rd_data = '0;
    logic [NCH-1:0]    rd_cs, wr_cs, rd_seen, wr_seen, exp_cs;
    logic [DW-1:0]     wr_data, got, exp_d, m_wr, zv;
    logic [DW-1:0]     shadow_m [NCH];
    logic              bus_err, m_err, ok;
    logic [AW-1:0]     a;
    int                tests = 0, fails = 0, rd_hits = 0, wr_hits = 0, multi = 0;

    assign data = tb_oe ? tb_dq : 'z;

    mcu_bus_bridge #(.AW(AW), .DW(DW), .NCH(NCH), .BASE(12'h000), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .ADDR(addr), .RD(rd), .WR(wr), .DATA(data),
        .rd_data(rd_data), .rd_cs(rd_cs), .wr_cs(wr_cs), .wr_data(wr_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rd_cs != '0) begin rd_hits++; rd_seen |= rd_cs; end
        if (wr_cs != '0) begin wr_hits++; wr_seen |= wr_cs; end
        if ($countones(rd_cs | wr_cs) > 1) multi++;
    endtask

    task automatic clr();
        rd_hits = 0; wr_hits = 0; rd_seen = '0; wr_seen = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] ad, input int low, input bit scramble, output logic [DW-1:0] q);
        addr = ad;
        tick();
        clr();
        rd = 1'b0;
        for (int i = 0; i < low; i++) begin
            tick();
            if (scramble && i == S + 1) rd_data = {$urandom, $urandom, $urandom, $urandom};
        end
        q = data;
        rd = 1'b1;
        repeat (S + 3) tick();
    endtask

    task automatic do_write(input logic [AW-1:0] ad, input logic [DW-1:0] d, input int low);
        addr = ad;
        tick();
        clr();
        tb_dq = d; tb_oe = 1'b1; wr = 1'b0;
        repeat (low) tick();
        wr = 1'b1;
        repeat (S + 2) tick();
        tb_oe = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        zv = 'z;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_rd_cs", 64'(rd_cs), 64'h0);
        chk("rst_wr_cs", 64'(wr_cs), 64'h0);
        chk("rst_wr_data", 64'(wr_data), 64'h0);
        chk("rst_bus_err", 64'(bus_err), 64'h0);
        chk("rst_data_z", 64'(data), 64'(zv));

        // Read channel 3 with cycle-exact latency checks.
        rd_data[3*DW +: DW] = 16'hA5C3;
        rd_data[1*DW +: DW] = 16'h5E11;
        addr = 12'd3;
        tick();
        clr();
        rd = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == S + 1) begin
                chk("t1_data_z_early", 64'(data), 64'(zv));
                chk("t1_rd_cs", 64'(rd_cs), 64'h08);
            end
            if (i == S + 2) chk("t1_data", 64'(data), 64'hA5C3);
        end
        rd = 1'b1;
        for (int i = 1; i <= S + 2; i++) begin
            tick();
            if (i == S) chk("t1_data_held", 64'(data), 64'hA5C3);
            if (i == S + 1) chk("t1_data_released", 64'(data), 64'(zv));
        end
        chk("t1_rd_hits", 64'(rd_hits), 64'd1);
        chk("t1_wr_hits", 64'(wr_hits), 64'd0);

        // Write 0x1234 to channel 5 with cycle-exact strobe check.
        addr = 12'd5;
        tick();
        clr();
        tb_dq = 16'h1234; tb_oe = 1'b1; wr = 1'b0;
        repeat (5) tick();
        wr = 1'b1;
        for (int i = 1; i <= S + 2; i++) begin
            tick();
            if (i == S) begin
                chk("t2_wr_cs_early", 64'(wr_cs), 64'h0);
                chk("t2_wr_data_early", 64'(wr_data), 64'h0);
            end
            if (i == S + 1) begin
                chk("t2_wr_cs", 64'(wr_cs), 64'h20);
                chk("t2_wr_data", 64'(wr_data), 64'h1234);
            end
        end
        tb_oe = 1'b0;
        repeat (3) tick();
        chk("t2_wr_data_hold", 64'(wr_data), 64'h1234);
        chk("t2_wr_hits", 64'(wr_hits), 64'd1);
        chk("t2_bus_err_clear", 64'(bus_err), 64'h0);

        // RD and WR low together.
        clr();
        rd = 1'b0; wr = 1'b0;
        repeat (6) tick();
        chk("t4_data_z", 64'(data), 64'(zv));
        rd = 1'b1; wr = 1'b1;
        repeat (S + 3) tick();
        chk("t4_bus_err", 64'(bus_err), 64'h1);
        chk("t4_strobes", 64'(rd_hits + wr_hits), 64'd0);

        // Out-of-range read, then out-of-range write, each from a clean reset.
        do_reset();
        chk("t3_rst_err", 64'(bus_err), 64'h0);
        do_read(12'd9, 6, 1'b0, got);
        chk("t3_rd_data", 64'(got), 64'h0);
        chk("t3_rd_hits", 64'(rd_hits), 64'd0);
        chk("t3_rd_err", 64'(bus_err), 64'h1);
        do_reset();
        do_write(12'hFFF, 16'hBEEF, 5);
        chk("t3_wr_hits", 64'(wr_hits), 64'd0);
        chk("t3_wr_data", 64'(wr_data), 64'h0);
        chk("t3_wr_err", 64'(bus_err), 64'h1);
        repeat (4) tick();
        chk("t3_err_sticky", 64'(bus_err), 64'h1);

        // Reset in the middle of a driven read.
        do_write(12'd1, 16'h7777, 5);
        chk("t5_pre_wr_data", 64'(wr_data), 64'h7777);
        addr = 12'd3;
        tick();
        rd = 1'b0;
        repeat (S + 3) tick();
        chk("t5_pre_data", 64'(data), 64'hA5C3);
        rst = 1'b1;
        tick();
        chk("t5_data_z", 64'(data), 64'(zv));
        chk("t5_wr_data", 64'(wr_data), 64'h0);
        chk("t5_bus_err", 64'(bus_err), 64'h0);
        chk("t5_cs", 64'({rd_cs, wr_cs}), 64'h0);
        rst = 1'b0;
        clr();
        repeat (8) tick();
        chk("t5_no_rd_cs", 64'(rd_hits), 64'd0);
        chk("t5_still_z", 64'(data), 64'(zv));
        rd = 1'b1;
        repeat (S + 3) tick();
        do_read(12'd3, 6, 1'b0, got);
        chk("t5_read_after", 64'(got), 64'hA5C3);

        // Snapshot coherence on channel 2.
        rd_data = '0;
        rd_data[2*DW +: DW] = 16'h0001;
        do_read(12'd0, 6, 1'b0, got);
        chk("t6_ch0", 64'(got), 64'h0);
        rd_data[2*DW +: DW] = 16'h0002;
        do_read(12'd2, 6, 1'b0, got);
        chk("t6_ch2", 64'(got), SNAP ? 64'h0001 : 64'h0002);

        // Randomised transactions against the channel-map model.
        do_reset();
        m_err = 1'b0;
        m_wr = '0;
        for (int k = 0; k < NCH; k++) shadow_m[k] = '0;
        for (int n = 0; n < 40; n++) begin
            rd_data = {$urandom, $urandom, $urandom, $urandom};
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, NCH + 3));
            ok = a < AW'(NCH);
            exp_cs = ok ? NCH'(1) << a : '0;
            m_err |= !ok;
            if ($urandom_range(0, 1) == 1) begin
                exp_d = '0;
                if (ok) exp_d = (SNAP && a != 0) ? shadow_m[a] : rd_data[a*DW +: DW];
                if (ok && a == 0) for (int k = 0; k < NCH; k++) shadow_m[k] = rd_data[k*DW +: DW];
                do_read(a, $urandom_range(S + 3, S + 8), 1'b1, got);
                chk("rnd_rd_data", 64'(got), 64'(exp_d));
                chk("rnd_rd_cs", 64'(rd_seen), 64'(exp_cs));
                chk("rnd_rd_hits", 64'(rd_hits), 64'(ok));
                chk("rnd_rd_no_wr", 64'(wr_hits), 64'd0);
            end else begin
                exp_d = 16'($urandom);
                if (ok) m_wr = exp_d;
                do_write(a, exp_d, $urandom_range(2, 6));
                chk("rnd_wr_data", 64'(wr_data), 64'(m_wr));
                chk("rnd_wr_cs", 64'(wr_seen), 64'(exp_cs));
                chk("rnd_wr_hits", 64'(wr_hits), 64'(ok));
                chk("rnd_wr_no_rd", 64'(rd_hits), 64'd0);
            end
            chk("rnd_bus_err", 64'(bus_err), 64'(m_err));
            chk("rnd_idle_z", 64'(data), 64'(zv));
        end
        chk("onehot_strobes", 64'(multi), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
